// File: rtl/mux11_pkg.sv
// mux11_pkg: shared types and constants for the 11-requester round-robin
// arbiter that drives the mux11to1 select chain.
//   N      number of requesters (matches the mux width)
//   IDXW   width of a binary requester index
//   FW     width of the mux chain select vector f
//   state_t  arbiter FSM encoding
//   sel_of   index -> chain select mapping
package mux11_pkg;

  localparam int N    = 11;
  localparam int IDXW = 4;
  localparam int FW   = N - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // Stage 0 picks a0/a1 and stage k picks the running value or a[k+1], so
  // input i is reached by setting only bit i-1; input 0 needs every bit low.
  function automatic logic [FW-1:0] sel_of(input logic [IDXW-1:0] i);
    logic [FW-1:0] s;
    s = '0;
    for (int k = 1; k < N; k++) begin
      if (i == IDXW'(k)) s[k-1] = 1'b1;
    end
    return s;
  endfunction

endpackage

// File: rtl/mux11_rr_arbiter_rr_pick11.sv
// rr_pick11: combinational rotating-priority picker.
//   req   in  N     request vector
//   ptr   in  IDXW  index holding highest priority (0..N-1)
//   found out 1     at least one request is set
//   win   out IDXW  first set request at or above ptr, wrapping N-1 -> 0
module rr_pick11
  import mux11_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [IDXW-1:0] ptr,
  output logic            found,
  output logic [IDXW-1:0] win
);

  logic [IDXW:0]   sum;
  logic [IDXW-1:0] cand;

  always_comb begin
    found = 1'b0;
    win   = '0;
    sum   = '0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      // ptr + i can reach 20, so form it one bit wider before wrapping.
      sum = {1'b0, ptr} + (IDXW+1)'(i);
      if (sum >= (IDXW+1)'(N)) sum = sum - (IDXW+1)'(N);
      cand = sum[IDXW-1:0];
      if (!found && req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

endmodule

// File: rtl/mux11_rr_arbiter.sv
// mux11_rr_arbiter: round-robin arbiter and select sequencer for mux11to1.
// Grants one of N requesters at a time and drives the registered mux chain
// select f for the winner. Every grant is followed by a one-cycle GAP so two
// grants are never back to back.
//   clk, rst   rising-edge clock, asynchronous active-high reset
//   req        level requests, held while a requester wants the mux
//   gnt        registered one-hot grant
//   idx        binary index of the grantee, 0 when no grant is active
//   f          registered chain select; holds its last value between grants
//   busy       a grant is active
//   tmo        one-cycle pulse in the GAP cycle after a forced release
//   dbg_state  current FSM state (IDLE/GRANT/GAP encoding from mux11_pkg)
// Optional feature: define MUX11_ARB_TIMEOUT_EN to force-release a grant
// after MAX_HOLD cycles (1..255). Without it tmo is constant 0 and grants
// last as long as the request does.
// Handshake: req is a level; a requester owns the mux from the first cycle
// gnt shows its bit until the cycle after it drops req (or is timed out).
module mux11_rr_arbiter
  import mux11_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [IDXW-1:0] idx,
  output logic [FW-1:0]   f,
  output logic            busy,
  output logic            tmo,
  output logic [1:0]      dbg_state
);

  generate
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_hold
      $error("mux11_rr_arbiter: MAX_HOLD must be in 1..255");
    end
  endgenerate

  state_t          state;
  logic [IDXW-1:0] ptr;
  logic            found;
  logic [IDXW-1:0] win;
  logic [IDXW-1:0] ptr_next;

  rr_pick11 u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (found),
    .win   (win)
  );

  // Priority moves to the requester just after the one being released.
  assign ptr_next  = (idx == IDXW'(N-1)) ? '0 : idx + 1'b1;
  assign dbg_state = state;

`ifdef MUX11_ARB_TIMEOUT_EN
  logic [7:0] hold_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      idx      <= '0;
      f        <= '0;
      busy     <= 1'b0;
      tmo      <= 1'b0;
      ptr      <= '0;
      hold_cnt <= '0;
    end else begin
      tmo <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            gnt      <= N'(1) << win;
            idx      <= win;
            f        <= sel_of(win);
            busy     <= 1'b1;
            hold_cnt <= '0;
            state    <= GRANT;
          end
        end
        GRANT: begin
          // A request drop wins over a coincident timeout: no tmo pulse.
          if (!req[idx] || hold_cnt == 8'(MAX_HOLD-1)) begin
            tmo   <= req[idx];
            gnt   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            state <= GAP;
          end else if (hold_cnt != 8'hFF) begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      idx   <= '0;
      f     <= '0;
      busy  <= 1'b0;
      ptr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt   <= N'(1) << win;
            idx   <= win;
            f     <= sel_of(win);
            busy  <= 1'b1;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (!req[idx]) begin
            gnt   <= '0;
            idx   <= '0;
            busy  <= 1'b0;
            ptr   <= ptr_next;
            state <= GAP;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign tmo = 1'b0;
`endif

endmodule

// File: tb/tb_mux11_rr_arbiter.sv
module tb_mux11_rr_arbiter;

  logic        clk;
  logic        rst;
  logic [10:0] req;
  logic [10:0] gnt;
  logic [3:0]  idx;
  logic [9:0]  f;
  logic        busy;
  logic        tmo;
  logic [1:0]  dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected grant record: {idx, f, gnt}
  logic [24:0] exp_q[$];

  // Hand-computed select values for indices 0..10.
  logic [9:0] f_tab [0:10] = '{10'h000, 10'h001, 10'h002, 10'h004, 10'h008,
                               10'h010, 10'h020, 10'h040, 10'h080, 10'h100,
                               10'h200};

  mux11_rr_arbiter #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .gnt       (gnt),
    .idx       (idx),
    .f         (f),
    .busy      (busy),
    .tmo       (tmo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, expv,
               $time);
    end
  endtask

  function automatic logic [24:0] pack(input logic [3:0] i, input logic [9:0] s,
                                       input logic [10:0] g);
    return {i, s, g};
  endfunction

  // Waits up to 20 cycles for a grant; a timeout counts as a failure.
  task automatic wait_gnt();
    int  n;
    bit  seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < 20) begin
      @(negedge clk);
      n++;
      if (gnt != '0) seen = 1'b1;
    end
    check("wait_gnt", 32'(seen), 32'd1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic [10:0] prev_gnt = '0;
  logic [24:0] exp_rec;

  always @(negedge clk) begin
    if (gnt != '0 && prev_gnt == '0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_grant", 32'(gnt), 32'd0);
      end else begin
        exp_rec = exp_q.pop_front();
        check("grant_gnt", 32'(gnt), 32'(exp_rec[10:0]));
        check("grant_f",   32'(f),   32'(exp_rec[20:11]));
        check("grant_idx", 32'(idx), 32'(exp_rec[24:21]));
        check("grant_busy", 32'(busy), 32'd1);
      end
    end
    if (gnt != '0 && prev_gnt != '0 && gnt != prev_gnt)
      check("back_to_back", 32'(gnt), 32'(prev_gnt));
    prev_gnt = gnt;
  end

  // ---------------- stimulus ----------------
  initial begin
    int  cyc;
    bit  held_ok;
    bit  tmo_seen;

    rst = 1'b1;
    req = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_gnt",  32'(gnt),  32'd0);
    check("rst_idx",  32'(idx),  32'd0);
    check("rst_f",    32'(f),    32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_tmo",  32'(tmo),  32'd0);

    // Idle with no requests
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("idle_quiet", 32'({busy, f, gnt}), 32'd0);
    end

    // Requester 10 alone: one-edge latency, select 0x200
    exp_q.push_back(pack(4'd10, f_tab[10], 11'h400));
    req = 11'h400;
    @(negedge clk);
    check("lat_gnt", 32'(gnt), 32'h400);
    req = '0;
    @(negedge clk);
    check("rel_gnt",  32'(gnt),  32'd0);
    check("rel_busy", 32'(busy), 32'd0);
    check("gap_f_hold", 32'(f), 32'h200);
    repeat (2) @(negedge clk);

    // All requesters: order 0..10 then 0, each dropping after 2 cycles
    for (int g = 0; g < 12; g++)
      exp_q.push_back(pack(4'(g % 11), f_tab[g % 11], 11'(1) << (g % 11)));
    req = 11'h7FF;
    for (int g = 0; g < 12; g++) begin
      wait_gnt();
      @(negedge clk);
      check("rr_hold2", 32'(gnt), 32'(11'(1) << (g % 11)));
      req[g % 11] = 1'b0;
      @(negedge clk);
      check("rr_gap", 32'(gnt), 32'd0);
      if (g < 11) req[g % 11] = 1'b1;
      else        req = '0;
    end
    repeat (3) @(negedge clk);

`ifdef MUX11_ARB_TIMEOUT_EN
    // Forced release after MAX_HOLD=4 cycles, then requester 3
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(pack(4'd0, 10'h000, 11'h001));
    exp_q.push_back(pack(4'd3, 10'h004, 11'h008));
    req = 11'h009;
    wait_gnt();
    cyc = 1;
    tmo_seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (gnt == 11'h001) cyc++;
      else break;
    end
    check("tmo_hold_cycles", 32'(cyc), 32'd4);
    check("tmo_pulse", 32'(tmo), 32'd1);
    @(negedge clk);
    check("tmo_one_cycle", 32'(tmo), 32'd0);
    wait_gnt();
    check("tmo_next_f", 32'(f), 32'h004);
    req = '0;
    repeat (3) @(negedge clk);
`else
    // Held request is never released without the timeout feature
    exp_q.push_back(pack(4'd0, 10'h000, 11'h001));
    req = 11'h001;
    wait_gnt();
    held_ok  = 1'b1;
    tmo_seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (gnt != 11'h001) held_ok = 1'b0;
      if (tmo) tmo_seen = 1'b1;
    end
    check("long_hold", 32'(held_ok), 32'd1);
    check("no_tmo", 32'(tmo_seen), 32'd0);
    req = '0;
    repeat (3) @(negedge clk);
`endif

    // Asynchronous reset mid-grant to requester 5
    exp_q.push_back(pack(4'd5, 10'h010, 11'h020));
    req = 11'h020;
    wait_gnt();
    #2 rst = 1'b1;
    #1;
    check("arst_gnt",  32'(gnt),  32'd0);
    check("arst_idx",  32'(idx),  32'd0);
    check("arst_f",    32'(f),    32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_tmo",  32'(tmo),  32'd0);
    @(negedge clk);
    rst = 1'b0;
    // Pointer is back at 0, so requester 0 wins
    exp_q.push_back(pack(4'd0, 10'h000, 11'h001));
    req = 11'h7FF;
    wait_gnt();
    req = '0;
    repeat (4) @(negedge clk);

    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
